// File: rtl/meas_scheduler.sv
// Measurement cycle sequencer: opens the counter gate, waits for the
// measurement done pulse (or times out), latches the four 32-bit results and
// streams them as a framed 20-byte packet to the UART over valid/ready.
// Frame: HDR0, HDR1, status, cnt_clk, cnt_squ, cnt_pulse, cnt_time (each
// MSB first), checksum = mod-256 sum of status and the 16 payload bytes.
module meas_scheduler #(
    parameter int unsigned GATE_CYCLES    = 100000000,
    parameter int unsigned TIMEOUT_CYCLES = 200000000,
    parameter int unsigned GAP_CYCLES     = 1000000,
    parameter logic [7:0]  HDR0           = 8'hAA,
    parameter logic [7:0]  HDR1           = 8'h55
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_en,
    input  logic        meas_done,
    input  logic [31:0] cnt_clk,
    input  logic [31:0] cnt_squ,
    input  logic [31:0] cnt_pulse,
    input  logic [31:0] cnt_time,
    output logic        gate,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic [7:0]  frame_cnt
);

    localparam logic [31:0] GATE_LAST    = 32'(GATE_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] GAP_LAST     = 32'(GAP_CYCLES - 1);
    localparam logic [4:0]  LAST_BYTE    = 5'd19;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GATE,
        ST_WAIT_DONE,
        ST_LATCH,
        ST_SEND,
        ST_GAP
    } state_t;

    state_t       state_q;
    logic [31:0]  cnt_q;
    logic         to_flag_q;
    logic [31:0]  res_clk_q;
    logic [31:0]  res_squ_q;
    logic [31:0]  res_pulse_q;
    logic [31:0]  res_time_q;
    logic [7:0]   status_q;
    logic [7:0]   csum_q;
    logic [4:0]   byte_idx_q;
    logic         gate_q;
    logic         tx_valid_q;
    logic [7:0]   tx_data_q;
    logic         busy_q;
    logic [7:0]   frame_cnt_q;

    logic [4:0]   byte_sel;
    logic [3:0]   pay_off;
    logic [6:0]   pay_pos;
    logic [127:0] payload;
    logic [7:0]   csum_d;
    logic [7:0]   next_byte_d;

    // Next frame byte and running checksum, selected by the byte about to be presented
    always_comb begin
        byte_sel = byte_idx_q + 5'd1;
        payload  = {res_clk_q, res_squ_q, res_pulse_q, res_time_q};
        pay_off  = 4'(byte_sel - 5'd3);
        pay_pos  = 7'd127 - {pay_off, 3'b000};
        csum_d   = csum_q;
        if (byte_idx_q >= 5'd2 && byte_idx_q <= 5'd18) begin
            csum_d = csum_q + tx_data_q;
        end
        if (byte_sel == 5'd1) begin
            next_byte_d = HDR1;
        end else if (byte_sel == 5'd2) begin
            next_byte_d = status_q;
        end else if (byte_sel == LAST_BYTE) begin
            // checksum includes byte 18, which transfers on this same edge
            next_byte_d = csum_d;
        end else if (byte_sel >= 5'd3 && byte_sel <= 5'd18) begin
            next_byte_d = payload[pay_pos -: 8];
        end else begin
            next_byte_d = HDR0;
        end
    end

    // Measurement sequencing FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            to_flag_q   <= 1'b0;
            res_clk_q   <= '0;
            res_squ_q   <= '0;
            res_pulse_q <= '0;
            res_time_q  <= '0;
            status_q    <= '0;
            csum_q      <= '0;
            byte_idx_q  <= '0;
            gate_q      <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_en) begin
                        state_q <= ST_GATE;
                        gate_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                ST_GATE: begin
                    if (cnt_q == GATE_LAST) begin
                        state_q <= ST_WAIT_DONE;
                        gate_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (meas_done) begin
                        state_q   <= ST_LATCH;
                        to_flag_q <= 1'b0;
                        cnt_q     <= '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_q   <= ST_LATCH;
                        to_flag_q <= 1'b1;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                ST_LATCH: begin
                    res_clk_q   <= to_flag_q ? '0 : cnt_clk;
                    res_squ_q   <= to_flag_q ? '0 : cnt_squ;
                    res_pulse_q <= to_flag_q ? '0 : cnt_pulse;
                    res_time_q  <= to_flag_q ? '0 : cnt_time;
                    status_q    <= {frame_cnt_q[6:0], to_flag_q};
                    csum_q      <= '0;
                    byte_idx_q  <= '0;
                    tx_data_q   <= HDR0;
                    tx_valid_q  <= 1'b1;
                    state_q     <= ST_SEND;
                end
                ST_SEND: begin
                    if (tx_valid_q && tx_ready) begin
                        if (byte_idx_q == LAST_BYTE) begin
                            tx_valid_q  <= 1'b0;
                            frame_cnt_q <= frame_cnt_q + 8'd1;
                            cnt_q       <= '0;
                            state_q     <= ST_GAP;
                        end else begin
                            byte_idx_q <= byte_sel;
                            tx_data_q  <= next_byte_d;
                            csum_q     <= csum_d;
                        end
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    gate_q     <= 1'b0;
                    tx_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign gate      = gate_q;
    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;

endmodule
